// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution unit: branch funct3 encodings
// and the 2-bit bimodal counter state.
package br_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

endpackage

// File: rtl/br_bht.sv
// Bimodal branch history table: one combinational read port for fetch and one
// saturating-counter write port for execute; reset puts every entry at WNT.
module br_bht
    import br_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_state_e entries_q [ENTRIES];

    function automatic bht_state_e sat_update(input bht_state_e s, input logic taken);
        bht_state_e n;
        case (s)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            default: n = taken ? ST  : WT;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= WNT;
            end
        end else if (wr_en) begin
            entries_q[wr_idx] <= sat_update(entries_q[wr_idx], wr_taken);
        end
    end

    // No write-to-read bypass: a same-index lookup sees the pre-update state.
    assign rd_taken = entries_q[rd_idx][1];

endmodule

// File: rtl/brc.sv
// Combinational branch comparator: less/equal flags for two 32-bit operands,
// signed when i_br_un is 1, unsigned otherwise.
module brc (
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_br_un,
    output logic        o_br_less,
    output logic        o_br_equal
);

    logic signed [31:0] rs1_s;
    logic signed [31:0] rs2_s;

    assign rs1_s      = i_rs1;
    assign rs2_s      = i_rs2;
    assign o_br_equal = (i_rs1 == i_rs2);
    assign o_br_less  = i_br_un ? (rs1_s < rs2_s) : (i_rs1 < i_rs2);

endmodule

// File: rtl/br_unit.sv
// Execute-stage branch resolution: drives the brc signedness select, resolves
// taken/mispredict from brc flags, trains the BHT and counts branches.
module br_unit
    import br_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_f_pc,
    output logic        o_f_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_pred_taken,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_ex_taken,
    output logic        o_ex_mispredict,
    output logic        o_ex_illegal,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic             br_valid;
    logic             cond_taken;
    logic             rsvd_funct3;
    logic             act;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc_bits;

    always_comb begin
        o_br_un     = 1'b0;
        cond_taken  = 1'b0;
        rsvd_funct3 = 1'b0;
        case (i_ex_funct3)
            F3_BEQ:  cond_taken = i_br_equal;
            F3_BNE:  cond_taken = ~i_br_equal;
            F3_BLT: begin
                cond_taken = i_br_less;
                o_br_un    = 1'b1;
            end
            F3_BGE: begin
                cond_taken = ~i_br_less;
                o_br_un    = 1'b1;
            end
            F3_BLTU: cond_taken = i_br_less;
            F3_BGEU: cond_taken = ~i_br_less;
            default: rsvd_funct3 = 1'b1;
        endcase
    end

    // Outputs are quiet unless a valid branch is present; illegal branches never resolve.
    assign br_valid        = i_ex_valid & i_ex_is_br;
    assign o_ex_illegal    = br_valid & rsvd_funct3;
    assign act             = br_valid & ~rsvd_funct3;
    assign o_ex_taken      = act & cond_taken;
    assign o_ex_mispredict = act & (cond_taken != i_ex_pred_taken);

    assign f_idx  = i_f_pc[IDX_W+1:2];
    assign ex_idx = i_ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{i_f_pc[31:IDX_W+2], i_f_pc[1:0],
                              i_ex_pc[31:IDX_W+2], i_ex_pc[1:0]};

    br_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (i_clk),
        .reset    (i_reset),
        .rd_idx   (f_idx),
        .rd_taken (o_f_pred_taken),
        .wr_en    (act),
        .wr_idx   (ex_idx),
        .wr_taken (cond_taken)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_br_count      <= '0;
            o_mispred_count <= '0;
        end else if (act) begin
            o_br_count <= o_br_count + 32'd1;
            if (o_ex_mispredict) begin
                o_mispred_count <= o_mispred_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_br_unit.sv
// Bench for br_unit wired to a real brc: behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_br_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic        f_pred;
    logic        ex_valid;
    logic        ex_is_br;
    logic [2:0]  ex_f3;
    logic [31:0] ex_pc;
    logic        ex_pred;
    logic        br_un;
    logic        br_less;
    logic        br_equal;
    logic        ex_taken;
    logic        ex_misp;
    logic        ex_ill;
    logic [31:0] br_count;
    logic [31:0] mis_count;
    logic [31:0] rs1;
    logic [31:0] rs2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    int          bht_m [16];
    logic [31:0] cnt_m;
    logic [31:0] mis_m;

    always #5 clk = ~clk;

    br_unit #(.BHT_ENTRIES(16)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_f_pc          (f_pc),
        .o_f_pred_taken  (f_pred),
        .i_ex_valid      (ex_valid),
        .i_ex_is_br      (ex_is_br),
        .i_ex_funct3     (ex_f3),
        .i_ex_pc         (ex_pc),
        .i_ex_pred_taken (ex_pred),
        .o_br_un         (br_un),
        .i_br_less       (br_less),
        .i_br_equal      (br_equal),
        .o_ex_taken      (ex_taken),
        .o_ex_mispredict (ex_misp),
        .o_ex_illegal    (ex_ill),
        .o_br_count      (br_count),
        .o_mispred_count (mis_count)
    );

    brc u_brc (
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .i_br_un    (br_un),
        .o_br_less  (br_less),
        .o_br_equal (br_equal)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    // Architectural meaning of each funct3, straight from the ISA.
    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return !($signed(a) < $signed(b));
            3'd6: return a < b;
            3'd7: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) bht_m[i] = 1;
            cnt_m = 0;
            mis_m = 0;
        end else if (ex_valid && ex_is_br && ref_legal(ex_f3)) begin
            int k;
            bit t;
            k = int'(ex_pc[5:2]);
            t = ref_taken(ex_f3, rs1, rs2);
            if (t) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
            else   bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
            cnt_m = cnt_m + 1;
            if (t != ex_pred) mis_m = mis_m + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit isbr, legal, t;
            isbr  = ex_valid && ex_is_br;
            legal = ref_legal(ex_f3);
            t     = ref_taken(ex_f3, rs1, rs2);
            check("m_br_un",   {31'd0, br_un},    {31'd0, (ex_f3 == 3'd4 || ex_f3 == 3'd5)});
            check("m_taken",   {31'd0, ex_taken}, {31'd0, isbr && legal && t});
            check("m_misp",    {31'd0, ex_misp},  {31'd0, isbr && legal && (t != ex_pred)});
            check("m_illegal", {31'd0, ex_ill},   {31'd0, isbr && !legal});
            check("m_fpred",   {31'd0, f_pred},   {31'd0, bht_m[f_pc[5:2]] >= 2});
            check("m_brcnt",   br_count,  cnt_m);
            check("m_miscnt",  mis_count, mis_m);
        end
    end

    task automatic step(input bit r, input bit v, input bit b, input logic [2:0] f3,
                        input logic [31:0] pc, input bit pred, input logic [31:0] a,
                        input logic [31:0] bb, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        rst = r; ex_valid = v; ex_is_br = b; ex_f3 = f3; ex_pc = pc;
        ex_pred = pred; rs1 = a; rs2 = bb; f_pc = fpc;
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, fpc);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_is_br = 0; ex_f3 = 0; ex_pc = 0;
        ex_pred = 0; rs1 = 0; rs2 = 0; f_pc = 0;
        step(1'b1, 0, 0, 3'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 0, 0, 3'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
        chk_en = 1'b1;

        // Reset state
        idle(32'h40);
        check("rst_fpred", {31'd0, f_pred}, 32'd0);
        check("rst_brcnt", br_count, 32'd0);
        check("rst_miscnt", mis_count, 32'd0);

        // BLT -3 < 2 signed, predicted not-taken
        step(0, 1, 1, 3'b100, 32'h10, 0, 32'hFFFF_FFFD, 32'd2, 32'h10);
        check("blt_un", {31'd0, br_un}, 32'd1);
        check("blt_taken", {31'd0, ex_taken}, 32'd1);
        check("blt_misp", {31'd0, ex_misp}, 32'd1);
        idle(32'h10);
        check("blt_brcnt", br_count, 32'd1);
        check("blt_miscnt", mis_count, 32'd1);
        check("blt_fpred", {31'd0, f_pred}, 32'd1);

        // BLTU 0xFFFFFFFF < 1 unsigned is false; three times saturates at SNT
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 3'b110, 32'h20, 0, 32'hFFFF_FFFF, 32'd1, 32'h20);
            check("bltu_un", {31'd0, br_un}, 32'd0);
            check("bltu_taken", {31'd0, ex_taken}, 32'd0);
            check("bltu_misp", {31'd0, ex_misp}, 32'd0);
        end
        // One taken from SNT only reaches WNT
        step(0, 1, 1, 3'b000, 32'h20, 0, 32'd7, 32'd7, 32'h20);
        idle(32'h20);
        check("snt_sat_fpred", {31'd0, f_pred}, 32'd0);
        check("bltu_brcnt", br_count, 32'd5);

        // PC 0x40: three taken -> ST; old value visible during each update
        step(0, 1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5, 32'h40);
        check("byp_first", {31'd0, f_pred}, 32'd0);
        step(0, 1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5, 32'h40);
        check("byp_second", {31'd0, f_pred}, 32'd1);
        step(0, 1, 1, 3'b000, 32'h40, 0, 32'd5, 32'd5, 32'h40);
        step(0, 1, 1, 3'b001, 32'h40, 1, 32'd5, 32'd5, 32'h40);
        check("bne_misp", {31'd0, ex_misp}, 32'd1);
        idle(32'h40);
        check("st_to_wt_fpred", {31'd0, f_pred}, 32'd1);
        step(0, 1, 1, 3'b001, 32'h40, 1, 32'd5, 32'd5, 32'h40);
        idle(32'h40);
        check("wt_to_wnt_fpred", {31'd0, f_pred}, 32'd0);
        check("seq_brcnt", br_count, 32'd10);
        check("seq_miscnt", mis_count, 32'd7);

        // Reserved funct3 on a WT entry: flagged, no update, no count
        step(0, 1, 1, 3'b010, 32'h10, 0, 32'd9, 32'd9, 32'h10);
        check("ill_flag", {31'd0, ex_ill}, 32'd1);
        check("ill_taken", {31'd0, ex_taken}, 32'd0);
        idle(32'h10);
        check("ill_fpred", {31'd0, f_pred}, 32'd1);
        check("ill_brcnt", br_count, 32'd10);
        check("ill_miscnt", mis_count, 32'd7);

        // Reset collides with a taken BEQ at 0x80
        step(1, 1, 1, 3'b000, 32'h80, 0, 32'd3, 32'd3, 32'h80);
        check("rstcol_taken", {31'd0, ex_taken}, 32'd1);
        idle(32'h80);
        check("rstcol_fpred", {31'd0, f_pred}, 32'd0);
        check("rstcol_brcnt", br_count, 32'd0);
        check("rstcol_miscnt", mis_count, 32'd0);
        idle(32'h10);
        check("rstcol_clear", {31'd0, f_pred}, 32'd0);

        // Randomised traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, bb;
            a  = $urandom;
            bb = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a  = $urandom_range(0, 7) - 3;
                bb = $urandom_range(0, 7) - 3;
            end
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
                 $urandom & 32'hFFFF_F03F, 1'($urandom_range(0, 1)), a, bb,
                 $urandom & 32'hFFFF_F03F);
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
